// File: rtl/nes_kbd_pad.sv
// NES joypad emulation fed by PS/2 make/break events.
// Presents the button state to the CPU through the standard strobe/serial-read port protocol.
module nes_kbd_pad #(
    parameter logic [7:0] KEY_A     = 8'h1A,
    parameter logic [7:0] KEY_B     = 8'h22,
    parameter logic [7:0] KEY_SEL   = 8'h59,
    parameter logic [7:0] KEY_START = 8'h5A,
    parameter logic [7:0] KEY_UP    = 8'h75,
    parameter logic [7:0] KEY_DOWN  = 8'h72,
    parameter logic [7:0] KEY_LEFT  = 8'h6B,
    parameter logic [7:0] KEY_RIGHT = 8'h74
) (
    input  logic       Clk,
    input  logic       reset_n,
    input  logic [7:0] keyCode,
    input  logic       press,
    input  logic       strobe_we,
    input  logic       strobe_d,
    input  logic       rd,
    output logic       data_out,
    output logic [7:0] buttons
);

    logic [8:0] r_prevEvt;
    logic [7:0] r_buttons;
    logic [7:0] r_shift;
    logic       r_strobe;
    logic       w_event;
    logic       w_shift;

    assign w_event = ({keyCode, press} != r_prevEvt);
    // A read that coincides with a strobe write must not consume a bit.
    assign w_shift = rd && !strobe_we;

    always_ff @(posedge Clk) begin
        if (!reset_n) begin
            r_prevEvt <= 9'd0;
            r_buttons <= 8'h00;
            r_strobe  <= 1'b0;
            r_shift   <= 8'hFF;
        end else begin
            r_prevEvt <= {keyCode, press};

            if (w_event) begin
                case (keyCode)
                    KEY_A:     r_buttons[0] <= press;
                    KEY_B:     r_buttons[1] <= press;
                    KEY_SEL:   r_buttons[2] <= press;
                    KEY_START: r_buttons[3] <= press;
                    KEY_UP:    r_buttons[4] <= press;
                    KEY_DOWN:  r_buttons[5] <= press;
                    KEY_LEFT:  r_buttons[6] <= press;
                    KEY_RIGHT: r_buttons[7] <= press;
                    default:   ;
                endcase
            end

            if (strobe_we) begin
                r_strobe <= strobe_d;
            end

            // Ones shift in from the top so reads past the eighth return 1.
            if (r_strobe) begin
                r_shift <= r_buttons;
            end else if (w_shift) begin
                r_shift <= {1'b1, r_shift[7:1]};
            end
        end
    end

    assign data_out = r_shift[0];
    assign buttons  = r_buttons;

endmodule

// File: doc/nes_kbd_pad.md
Name: nes_kbd_pad

Overview:
- Downstream consumer of the PS/2 keyboard decoder's `keyCode`/`press` pair.
- Maintains an 8-button NES joypad state from mapped key make/break events.
- Presents that state to the CPU through the standard NES controller port protocol: strobe write to $4016 bit 0, serial reads from $4016/$4017 bit 0.
- Sits between the keyboard decoder and the CPU memory-mapped I/O decode.

Parameters:
- KEY_A, 8'h1A, scan code mapped to A (Z key)
- KEY_B, 8'h22, scan code mapped to B (X key)
- KEY_SEL, 8'h59, scan code mapped to Select (right Shift)
- KEY_START, 8'h5A, scan code mapped to Start (Enter)
- KEY_UP, 8'h75, Up (arrow; E0 prefix already stripped upstream)
- KEY_DOWN, 8'h72, Down
- KEY_LEFT, 8'h6B, Left
- KEY_RIGHT, 8'h74, Right

Ports:
- Clk  in  1  system clock; all logic on posedge
- reset_n  in  1  synchronous reset, active-low
- keyCode  in  8  current scan code from keyboard decoder (level, Clk domain)
- press  in  1  1 = keyCode held, 0 = keyCode released (level)
- strobe_we  in  1  1-cycle pulse: CPU write to $4016
- strobe_d  in  1  CPU write data bit 0
- rd  in  1  1-cycle pulse: CPU read of this controller port
- data_out  out  1  serial button bit returned to CPU (bit 0 of read data)
- buttons  out  8  live button state {Right,Left,Down,Up,Start,Select,B,A}, bit0 = A

Behaviour:
- Reset (reset_n=0 at posedge):
  - buttons=0, strobe=0, shift_reg=8'hFF, prev_evt={8'h00,0}.
  - Therefore data_out=1.
  - Reset overrides every other input in that cycle.
- Event detect:
  - prev_evt registers {keyCode,press} every cycle.
  - An event occurs when {keyCode,press} != prev_evt.
  - Held keys produce no repeat events.
- Button update, on event only:
  - If keyCode equals a KEY_* parameter: bit := press.
  - Unmapped codes, including 8'hF0 and 8'h0F: no change.
  - Exactly one bit changes per event.
  - Other bits are untouched, so multiple buttons may be held simultaneously.
  - buttons is valid 1 cycle after the input change (registered).
- Strobe register: on strobe_we, strobe := strobe_d.
- Shift register:
  - While strobe=1 (registered value), shift_reg := buttons every cycle. data_out therefore tracks live A.
  - When strobe=0, shift_reg is frozen except on rd.
  - The latch snapshot is the buttons value in the last cycle strobe was 1.
- Read:
  - data_out = shift_reg[0], combinational from the register.
  - CPU samples data_out in the same cycle rd is high.
  - At that posedge, if strobe=0: shift_reg := {1'b1, shift_reg[7:1]}.
- Read order is A,B,Select,Start,Up,Down,Left,Right.
- The 9th and all later reads return 1 (ones fill). No counter is needed; there is no wrap.
- rd while strobe=1: no shift; returns live A.
- Simultaneous strobe_we and rd in the same cycle:
  - The read returns current data_out.
  - Shift is suppressed; the strobe update takes effect.
  - If strobe_d=1, reload begins next cycle.
- A keyboard event during a strobe=0 read sequence updates buttons but not the latched shift_reg.
- Reset mid-sequence: shift_reg=8'hFF and buttons=0 immediately. A new strobe is required to obtain fresh state.

Test Plan:
- Reset: hold reset_n=0 for 2 cycles, then release -> buttons=8'h00, data_out=1; 8 reads return all 1s.
- Single key:
  - Step 1: keyCode=8'h1A, press=1 -> buttons=8'h01 one cycle later.
  - Step 2: strobe 1 then 0, then 8 rd pulses -> data_out sequence 1,0,0,0,0,0,0,0.
  - Step 3: 9th read -> 1.
- Multi-key:
  - Step 1: press 8'h5A then 8'h74 (press=1 each, at least 2 cycles apart) -> buttons=8'h88.
  - Step 2: latch and read -> 0,0,0,1,0,0,0,1.
  - Step 3: keyCode=8'h5A, press=0 -> buttons=8'h80.
- Unmapped/hold:
  - Step 1: keyCode=8'h1C press=1, then 8'hF0 press=0 -> buttons unchanged.
  - Step 2: hold 8'h22 press=1 for 100 cycles -> bit1 set once; no toggling.
- Latch isolation:
  - Step 1: latch with buttons=8'h01.
  - Step 2: after 2 reads, press 8'h75.
  - Step 3: remaining reads -> 0,0,0,0,0,0 (Up not seen).
  - Step 4: next strobe -> Up=1 at read 5.
- Corner cases:
  - Strobe held at 1 with 3 rd pulses -> each returns live A.
  - strobe_we=1, strobe_d=0 coincident with rd -> returns A; first post-latch read also returns A.
  - reset_n=0 after 3 reads -> data_out=1 next cycle.
